// File: rtl/stopwatch_up_pkg.sv
// rtl/stopwatch_up_pkg.sv - shared states, widths and H:M:S type for the stopwatch block
package stopwatch_pkg;

  localparam int HOUR_W = 5;
  localparam int MS_W   = 6;

  localparam logic [MS_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MS_W-1:0] MIN_MAX = 6'd59;

  // Two-bit encoding is shared with the display mux and legacy status readers.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_STOPPED = 2'd1;
  localparam logic [1:0] ST_RUNNING = 2'd2;
  localparam logic [1:0] ST_FULL    = 2'd3;

  typedef struct packed {
    logic [HOUR_W-1:0] h;
    logic [MS_W-1:0]   m;
    logic [MS_W-1:0]   s;
  } hms_t;

  localparam hms_t HMS_ZERO = '0;

endpackage

// File: rtl/stopwatch_up_if.sv
// rtl/stopwatch_up_if.sv - switch inputs and display bus between panel and stopwatch
interface stopwatch_if;
  import stopwatch_pkg::*;

  logic              mode_in;
  logic              start_stop;
  logic              lap_in;
  logic              clear_in;
  logic [HOUR_W-1:0] hour_out;
  logic [MS_W-1:0]   min_out;
  logic [MS_W-1:0]   sec_out;
  logic              running;
  logic              lap_active;
  logic              overflow;

  modport master (
    output mode_in, start_stop, lap_in, clear_in,
    input  hour_out, min_out, sec_out, running, lap_active, overflow
  );

  modport slave (
    input  mode_in, start_stop, lap_in, clear_in,
    output hour_out, min_out, sec_out, running, lap_active, overflow
  );

endinterface

// File: rtl/stopwatch_up_hms_incr.sv
// rtl/stopwatch_up_hms_incr.sv - combinational H:M:S +1 with carries, holds at MAX_HOUR:59:59
module hms_incr
  import stopwatch_pkg::*;
#(
  parameter int MAX_HOUR = 12
) (
  input  hms_t cur_i,
  output hms_t nxt_o,
  output logic at_max_o
);

  localparam logic [HOUR_W-1:0] MAX_H = HOUR_W'(MAX_HOUR);

  assign at_max_o = (cur_i.h == MAX_H) && (cur_i.m == MIN_MAX) && (cur_i.s == SEC_MAX);

  always_comb begin
    nxt_o = cur_i;
    if (!at_max_o) begin
      if (cur_i.s == SEC_MAX) begin
        nxt_o.s = '0;
        if (cur_i.m == MIN_MAX) begin
          nxt_o.m = '0;
          nxt_o.h = cur_i.h + 1'b1;
        end else begin
          nxt_o.m = cur_i.m + 1'b1;
        end
      end else begin
        nxt_o.s = cur_i.s + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_up.sv
// rtl/stopwatch_up.sv - count-up stopwatch; optional lap freeze under STOPWATCH_LAP_EN
module stopwatch_up
  import stopwatch_pkg::*;
#(
  parameter int MAX_HOUR = 12
) (
  input  logic         clk_1Hz,
  input  logic         resetn,
  stopwatch_if.slave   sw
);

  logic [1:0] state_q, state_d;
  hms_t       cnt_q, cnt_d;
  hms_t       inc_nxt;
  logic       inc_at_max;
  hms_t       disp;

  hms_incr #(.MAX_HOUR(MAX_HOUR)) u_incr (
    .cur_i    (cnt_q),
    .nxt_o    (inc_nxt),
    .at_max_o (inc_at_max)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!sw.mode_in) begin
      state_d = ST_IDLE;
      cnt_d   = HMS_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d   = HMS_ZERO;
          state_d = ST_STOPPED;
        end
        ST_STOPPED: begin
          if (sw.start_stop) state_d = ST_RUNNING;
          else if (sw.clear_in) cnt_d = HMS_ZERO;
        end
        ST_RUNNING: begin
          // The stopping edge still counts, so the held value is one past the last shown.
          cnt_d = inc_nxt;
          if (inc_at_max) state_d = ST_FULL;
          else if (!sw.start_stop) state_d = ST_STOPPED;
        end
        default: begin
          if (sw.clear_in) begin
            state_d = ST_STOPPED;
            cnt_d   = HMS_ZERO;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_1Hz) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= HMS_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  hms_t lap_q, lap_d;
  logic lap_active_q, lap_active_d;

  always_comb begin
    lap_d        = lap_q;
    lap_active_d = lap_active_q;
    if (!sw.mode_in || state_q == ST_IDLE) begin
      lap_active_d = 1'b0;
    end else if (state_q == ST_STOPPED) begin
      // In STOPPED a lap pulse can only release the freeze, never capture.
      if ((!sw.start_stop && sw.clear_in) || sw.lap_in) lap_active_d = 1'b0;
    end else if (state_q == ST_RUNNING && sw.lap_in) begin
      if (!lap_active_q) begin
        lap_d        = inc_nxt;
        lap_active_d = 1'b1;
      end else begin
        lap_active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_1Hz) begin
    if (!resetn) begin
      lap_q        <= HMS_ZERO;
      lap_active_q <= 1'b0;
    end else begin
      lap_q        <= lap_d;
      lap_active_q <= lap_active_d;
    end
  end

  assign disp          = lap_active_q ? lap_q : cnt_q;
  assign sw.lap_active = lap_active_q;
`else
  logic unused_lap_in;
  assign unused_lap_in = sw.lap_in;
  assign disp          = cnt_q;
  assign sw.lap_active = 1'b0;
`endif

  assign sw.hour_out = disp.h;
  assign sw.min_out  = disp.m;
  assign sw.sec_out  = disp.s;
  assign sw.running  = (state_q == ST_RUNNING);
  assign sw.overflow = (state_q == ST_FULL);

endmodule

// File: tb/tb_stopwatch_up.sv
// tb/tb_stopwatch_up.sv - scoreboard bench for stopwatch_up (MAX_HOUR = 1)
module tb_stopwatch_up;
  import stopwatch_pkg::*;

  localparam int MAXH = 1;
  localparam int MAXT = MAXH * 3600 + 3599;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  stopwatch_if sw_if ();

  stopwatch_up #(.MAX_HOUR(MAXH)) u_dut (
    .clk_1Hz (clk),
    .resetn  (resetn),
    .sw      (sw_if)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: count kept as total seconds, states as plain ints.
  int m_st  = 0;
  int m_t   = 0;
  int m_lap = 0;
  int m_act = 0;

  logic [19:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [19:0] model_vec();
    int shown;
    int h;
    int mi;
    int s;
    logic r;
    logic o;
    shown = (m_act != 0) ? m_lap : m_t;
    h  = shown / 3600;
    mi = (shown / 60) % 60;
    s  = shown % 60;
    r  = (m_st == 2);
    o  = (m_st == 3);
    return {h[4:0], mi[5:0], s[5:0], r, (m_act != 0), o};
  endfunction

  function automatic logic [19:0] dut_vec();
    return {sw_if.hour_out, sw_if.min_out, sw_if.sec_out,
            sw_if.running, sw_if.lap_active, sw_if.overflow};
  endfunction

  task automatic model_edge();
    int nxt;
    if (!resetn) begin
      m_st = 0; m_t = 0; m_lap = 0; m_act = 0;
    end else if (!sw_if.mode_in) begin
      m_st = 0; m_t = 0; m_act = 0;
    end else begin
      case (m_st)
        0: begin m_t = 0; m_act = 0; m_st = 1; end
        1: begin
          if (sw_if.start_stop) m_st = 2;
          else if (sw_if.clear_in) begin m_t = 0; m_act = 0; end
          if (LAP && sw_if.lap_in && m_act != 0) m_act = 0;
        end
        2: begin
          nxt = (m_t == MAXT) ? m_t : m_t + 1;
          if (m_t == MAXT) m_st = 3;
          else if (!sw_if.start_stop) m_st = 1;
          if (LAP && sw_if.lap_in) begin
            if (m_act == 0) begin m_lap = nxt; m_act = 1; end
            else m_act = 0;
          end
          m_t = nxt;
        end
        default: if (sw_if.clear_in) begin m_st = 1; m_t = 0; end
      endcase
    end
  endtask

  task automatic step(input string tag);
    logic [19:0] e;
    model_edge();
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq(tag, {12'd0, dut_vec()}, {12'd0, e});
  endtask

  task automatic run_to(input int target, input string tag);
    int n = 0;
    while (m_t != target && n < 10000) begin
      step(tag);
      n++;
    end
    if (m_t != target) check_eq({tag, "_timeout"}, m_t, target);
  endtask

  task automatic pulse_lap(input string tag);
    sw_if.lap_in = 1'b1;
    step(tag);
    sw_if.lap_in = 1'b0;
  endtask

  task automatic pulse_clear(input string tag);
    sw_if.clear_in = 1'b1;
    step(tag);
    sw_if.clear_in = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    sw_if.mode_in    = 1'b0;
    sw_if.start_stop = 1'b0;
    sw_if.lap_in     = 1'b0;
    sw_if.clear_in   = 1'b0;
    step("reset");
    step("reset");
    check_eq("reset_outs", {12'd0, dut_vec()}, 32'd0);

    resetn = 1'b1;
    sw_if.mode_in    = 1'b1;
    sw_if.start_stop = 1'b1;
    step("to_stopped");
    check_eq("stopped_running", sw_if.running, 0);
    step("to_running");
    check_eq("running_flag", sw_if.running, 1);
    repeat (3) step("first_secs");
    check_eq("sec_after_5", sw_if.sec_out, 3);

    run_to(59, "carry_sec");
    step("carry_sec");
    check_eq("carry_min", {sw_if.min_out, sw_if.sec_out}, {6'd1, 6'd0});
    run_to(3599, "carry_min");
    step("carry_hour");
    check_eq("carry_hour", {sw_if.hour_out, sw_if.min_out, sw_if.sec_out}, {5'd1, 6'd0, 6'd0});

    run_to(MAXT, "saturate");
    step("saturate");
    check_eq("sat_hold", {sw_if.hour_out, sw_if.min_out, sw_if.sec_out}, {5'd1, 6'd59, 6'd59});
    check_eq("sat_flags", {sw_if.running, sw_if.overflow}, 2'b01);
    step("sat_hold2");
    pulse_clear("full_clear");
    check_eq("full_clear", {sw_if.sec_out, sw_if.running, sw_if.overflow}, {6'd0, 2'b00});

    step("restart");
    run_to(10, "lap_prep");
    pulse_lap("lap_on");
    check_eq("lap_on_val", {sw_if.sec_out, sw_if.lap_active}, {6'd11, LAP});
    repeat (5) step("lap_frozen");
    check_eq("lap_frozen", sw_if.sec_out, LAP ? 11 : 16);
    run_to(16, "lap_prep2");
    pulse_lap("lap_off");
    check_eq("lap_off_val", {sw_if.sec_out, sw_if.lap_active}, {6'd17, 1'b0});

    run_to(20, "stop_prep");
    sw_if.start_stop = 1'b0;
    step("stop");
    check_eq("stop_edge", {sw_if.sec_out, sw_if.running}, {6'd21, 1'b0});
    repeat (2) step("stop_hold");
    check_eq("stop_hold", sw_if.sec_out, 21);
    sw_if.start_stop = 1'b1;
    pulse_clear("start_beats_clear");
    check_eq("start_beats_clear", {sw_if.sec_out, sw_if.running}, {6'd21, 1'b1});
    sw_if.start_stop = 1'b0;
    step("stop2");
    pulse_clear("stopped_clear");
    check_eq("stopped_clear", sw_if.sec_out, 0);
    sw_if.start_stop = 1'b1;
    step("restart2");
    run_to(5, "run_clear_prep");
    pulse_clear("run_clear_ignored");
    check_eq("run_clear_ignored", {sw_if.sec_out, sw_if.running}, {6'd6, 1'b1});

    sw_if.start_stop = 1'b0;
    pulse_lap("stop_with_lap");
    check_eq("stop_with_lap", {sw_if.sec_out, sw_if.running, sw_if.lap_active}, {6'd7, 1'b0, LAP});
    pulse_lap("stopped_lap_release");
    check_eq("stopped_lap_release", sw_if.lap_active, 0);
    sw_if.start_stop = 1'b1;
    step("restart3");
    run_to(120, "abort_prep");
    pulse_lap("abort_lap");
    run_to(125, "abort_prep2");
    sw_if.mode_in = 1'b0;
    step("mode_abort");
    check_eq("mode_abort", {12'd0, dut_vec()}, 32'd0);

    sw_if.mode_in = 1'b1;
    repeat (2) step("rerun");
    run_to(30, "reset_prep");
    pulse_lap("reset_lap");
    step("reset_prep2");
    resetn = 1'b0;
    step("mid_reset");
    check_eq("mid_reset", {12'd0, dut_vec()}, 32'd0);
    resetn = 1'b1;
    step("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
